vga_scene_ctrl: RTL

Frame-synchronous scene controller for the VGA pixel generator. Debounces the board switch selection into a display mode, applies mode changes only at the start of vertical blanking, and runs a per-frame radius animation state machine with a colour rotation for the circle modes. Sits between the switch inputs and timing generators on one side and the combinational pixel-colour logic on the other; it owns every per-frame configuration register the pixel logic reads.

---
 rtl/vga_scene_ctrl_if.sv | 23 ++
 rtl/vga_scene_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_scene_ctrl_if.sv
// Scene-controller bus: frame and selection inputs from the board side and the
// per-frame configuration registers read by the pixel-colour logic.
interface vga_scene_ctrl_if;
   logic       i_vblank;
   logic [1:0] i_sel;
   logic       i_pause;
   logic [1:0] o_mode;
   logic [9:0] o_radius;
   logic [2:0] o_color;
   logic [11:0] o_frame;
   logic [1:0] o_anim_state;
   logic       o_update;

   modport master (
      output i_vblank, i_sel, i_pause,
      input  o_mode, o_radius, o_color, o_frame, o_anim_state, o_update
   );

   modport slave (
      input  i_vblank, i_sel, i_pause,
      output o_mode, o_radius, o_color, o_frame, o_anim_state, o_update
   );
endinterface

// File: rtl/vga_scene_ctrl.sv
// Frame-synchronous scene controller: debounced mode selection applied at vblank
// start, plus a per-frame radius/colour animation for the pulsing-circle mode.
module vga_scene_ctrl #(
   parameter int unsigned RMIN     = 20,
   parameter int unsigned RMAX     = 200,
   parameter int unsigned RSTEP    = 2,
   parameter int unsigned RSTATIC  = 100,
   parameter int unsigned HOLD     = 30,
   parameter int unsigned DEBOUNCE = 4
) (
   input logic             i_clk,
   input logic             i_rst_n,
   vga_scene_ctrl_if.slave bus
);
   localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);
   localparam int unsigned HOLD_W = $clog2(HOLD + 1);
   localparam logic [CNT_W-1:0]  DEB_C     = CNT_W'(DEBOUNCE);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
   localparam logic [10:0] RMAX_X       = 11'(RMAX);
   localparam logic [10:0] RSTEP_X      = 11'(RSTEP);
   localparam logic [10:0] SHRINK_FLOOR = 11'(RMIN + RSTEP);
   localparam logic [9:0]  RMIN_R       = 10'(RMIN);
   localparam logic [9:0]  RMAX_R       = 10'(RMAX);
   localparam logic [9:0]  RSTEP_R      = 10'(RSTEP);
   localparam logic [9:0]  RSTATIC_R    = 10'(RSTATIC);

   typedef enum logic [1:0] {
      GROW     = 2'd0,
      HOLD_MAX = 2'd1,
      SHRINK   = 2'd2,
      HOLD_MIN = 2'd3
   } anim_state_e;

   // Colour rotation skips black: 7 -> 1 -> 2 ... -> 7.
   function automatic logic [2:0] next_color(input logic [2:0] c);
      logic [2:0] n;
      if (c == 3'd7) begin
         n = 3'd1;
      end else begin
         n = c + 3'd1;
      end
      return n;
   endfunction

   logic [1:0]        sync1_q, sync1_d, sync2_q, sync2_d;
   logic              vb_q, vb_d;
   logic [11:0]       frame_q, frame_d;
   logic [1:0]        cand_q, cand_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        mode_q, mode_d;
   logic [9:0]        radius_q, radius_d;
   logic [2:0]        color_q, color_d;
   anim_state_e       state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              update_q, update_d;
   logic              tick_s, apply_s;
   logic [10:0]       rad_up_s;

   // Next-state: debounce, mode application and animation FSM, all gated by the frame tick.
   always_comb begin
      sync1_d  = bus.i_sel;
      sync2_d  = sync1_q;
      vb_d     = bus.i_vblank;
      frame_d  = frame_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      radius_d = radius_q;
      color_d  = color_q;
      state_d  = state_q;
      hold_d   = hold_q;
      update_d = 1'b0;
      apply_s  = 1'b0;
      tick_s   = bus.i_vblank & ~vb_q;
      rad_up_s = {1'b0, radius_q} + RSTEP_X;

      if (tick_s) begin
         frame_d = frame_q + 12'd1;
         if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CNT_W'(1);
         end else if (cnt_q >= DEB_C) begin
            cnt_d = DEB_C;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         apply_s = (sync2_q == cand_q) && (cnt_d >= DEB_C) && (cand_q != mode_q);

         // A mode change pre-empts the animation step on the same tick.
         if (apply_s) begin
            mode_d = cand_q;
            case (cand_q)
               2'd3: begin
                  radius_d = RMIN_R;
                  state_d  = GROW;
               end
               2'd2:    radius_d = RSTATIC_R;
               default: radius_d = radius_q;
            endcase
         end else if ((mode_q == 2'd3) && !bus.i_pause) begin
            case (state_q)
               GROW: begin
                  if (rad_up_s >= RMAX_X) begin
                     radius_d = RMAX_R;
                     hold_d   = HOLD_W'(0);
                     state_d  = HOLD_MAX;
                  end else begin
                     radius_d = rad_up_s[9:0];
                  end
               end
               HOLD_MAX: begin
                  if (hold_q == HOLD_LAST) begin
                     state_d = SHRINK;
                  end else begin
                     hold_d = hold_q + HOLD_W'(1);
                  end
               end
               SHRINK: begin
                  if ({1'b0, radius_q} <= SHRINK_FLOOR) begin
                     radius_d = RMIN_R;
                     hold_d   = HOLD_W'(0);
                     color_d  = next_color(color_q);
                     state_d  = HOLD_MIN;
                  end else begin
                     radius_d = radius_q - RSTEP_R;
                  end
               end
               HOLD_MIN: begin
                  if (hold_q == HOLD_LAST) begin
                     state_d = GROW;
                  end else begin
                     hold_d = hold_q + HOLD_W'(1);
                  end
               end
               default: state_d = GROW;
            endcase
         end else begin
            mode_d = mode_q;
         end
         update_d = (mode_d != mode_q) || (radius_d != radius_q) || (color_d != color_q);
      end else begin
         update_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sync1_q  <= 2'd0;
         sync2_q  <= 2'd0;
         vb_q     <= 1'b0;
         frame_q  <= 12'd0;
         cand_q   <= 2'd0;
         cnt_q    <= CNT_W'(0);
         mode_q   <= 2'd0;
         radius_q <= RMIN_R;
         color_q  <= 3'd7;
         state_q  <= GROW;
         hold_q   <= HOLD_W'(0);
         update_q <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         vb_q     <= vb_d;
         frame_q  <= frame_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         radius_q <= radius_d;
         color_q  <= color_d;
         state_q  <= state_d;
         hold_q   <= hold_d;
         update_q <= update_d;
      end
   end

   assign bus.o_mode       = mode_q;
   assign bus.o_radius     = radius_q;
   assign bus.o_color      = color_q;
   assign bus.o_frame      = frame_q;
   assign bus.o_anim_state = state_q;
   assign bus.o_update     = update_q;
endmodule
